fp_adder_operand_unpack: RTL
============================

Name: fp_adder_operand_unpack

Overview:
- Pipelined input stage that sits directly upstream of the single-path FP adder.
- Accepts operand pairs in IEEE-754 binary layout plus an add/sub select, and classifies each operand.
- Repacks each operand into the library's internal word: {exception[1:0], sign, biased exponent, fraction}.
- Streams results out through a valid/ready handshake with full throughput and 2-cycle latency.

Parameters:
- size_mantissa, 24, mantissa width including hidden bit
- size_exponent, 8, exponent width
- size_exception_field, 2, exception field width
- zero, 0, exception code for zero
- normal_number, 1, exception code for a normal number
- infinity, 2, exception code for infinity
- NaN, 3, exception code for NaN
- ieee_size, size_mantissa+size_exponent, width of an IEEE input word
- size, size_mantissa+size_exponent+size_exception_field, width of an internal word

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  stage can accept the pair this cycle
- sub_i  in  1  operation select: 1 = A-B, 0 = A+B
- a_ieee_i  in  ieee_size  operand A, IEEE layout {s, e, f}
- b_ieee_i  in  ieee_size  operand B, IEEE layout
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts the pair
- sub_o  out  1  registered sub_i
- a_number_o  out  size  operand A, internal format
- b_number_o  out  size  operand B, internal format

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: on rst, both pipeline stages are invalidated and data registers cleared; out_valid=0, sub_o=0, a_number_o=0, b_number_o=0. in_ready reads 1 in the first cycle after reset.
- Reset mid-operation: in-flight pairs are discarded, not delivered.
- Stage 1: registers {sub_i, a_ieee_i, b_ieee_i} when in_valid & in_ready.
- Stage 2: classifies and packs the stage-1 contents, registers the result, and drives the outputs.
- Latency: a pair accepted in cycle N appears with out_valid=1 in cycle N+2, provided out_ready is held high.
- Handshake:
  - s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv (combinational).
  - A transfer occurs on valid & ready at both ports.
  - Outputs hold stable while out_valid=1 & out_ready=0.
  - No data is lost or duplicated under any stall pattern.
  - Back-to-back transfers sustain 1 pair/cycle.
- Classification per operand (e = exponent field, f = fraction field of size_mantissa-1 bits):
  - e==0, f==0: exception=zero; sign kept; exp=0; frac=0.
  - e==0, f!=0 (denormal): flushed; exception=zero; sign kept; exp=0; frac=0.
  - e==all-ones, f==0: exception=infinity; sign kept; exp=all-ones; frac=0.
  - e==all-ones, f!=0: exception=NaN; sign kept; exp=all-ones; frac=f unchanged.
  - Otherwise: exception=normal_number; sign, e, f passed through unchanged. The exponent stays biased and the hidden bit is not stored.
- Internal word layout: [size-1:size-2]=exception; [size-3]=sign; next size_exponent bits = exponent; low size_mantissa-1 bits = fraction.
- A and B are classified independently. sub_i travels with its pair unchanged.

Optional Feature:
- Macro: FP_UNPACK_STATS_EN.
- When defined, the block adds:
  - outputs nan_count_o[15:0] and denorm_count_o[15:0];
  - input stats_clr (synchronous clear).
- Counting rules:
  - Counts increment when a pair transfers into stage 2.
  - Increment is +0, +1 or +2, according to how many of the pair's operands are NaN, or flushed denormals, respectively.
  - Counters saturate at 0xFFFF.
  - Both rst and stats_clr clear the counters. When stats_clr coincides with an increment, the clear wins.
- When the macro is undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Normal, infinity, NaN: a=0x3F800000, b=0x7F800000, sub_i=0. After 2 cycles, a_number_o=0x13F800000 and b_number_o=0x27F800000, sub_o=0. Repeat with b=0x7FC00000: b_number_o=0x37FC00000.
- Denormal flush and signed zero: a=0x00000001, b=0x80000001. Result a_number_o=0x000000000, b_number_o=0x080000000. With FP_UNPACK_STATS_EN, denorm_count_o goes 0→2.
- Stall: stream 4 distinct pairs back-to-back with out_ready=0 for cycles 3-6. Required: in_ready drops once both stages are full, output stays stable, and all 4 pairs emerge in order with no loss or duplication.
- Throughput: out_ready=1 and 16 consecutive valid pairs. Required: 16 outputs on 16 consecutive cycles, beginning 2 cycles after the first accept.
- Reset mid-stream: assert rst for 1 cycle while two pairs are in flight. Required: out_valid=0 and outputs zero the next cycle, and neither in-flight pair is ever delivered.
- Counter saturation and clear (macro on): preload the NaN count via 0xFFFF NaN operands; the count holds at 0xFFFF. Then assert stats_clr together with a NaN pair; the count reads 0.

Source files
------------

// File: rtl/fp_adder_operand_unpack.sv
// Two-stage operand unpack ahead of the FP adder: IEEE words in, classified internal words out.
// Optional NaN/denormal statistics counters are enabled with FP_UNPACK_STATS_EN.
module fp_adder_operand_unpack #(
  parameter int unsigned size_mantissa        = 24,
  parameter int unsigned size_exponent        = 8,
  parameter int unsigned size_exception_field = 2,
  parameter int unsigned zero                 = 0,
  parameter int unsigned normal_number        = 1,
  parameter int unsigned infinity             = 2,
  parameter int unsigned NaN                  = 3,
  localparam int unsigned ieee_size           = size_mantissa + size_exponent,
  localparam int unsigned size                = size_mantissa + size_exponent + size_exception_field
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub_i,
  input  logic [ieee_size-1:0] a_ieee_i,
  input  logic [ieee_size-1:0] b_ieee_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sub_o,
  output logic [size-1:0]      a_number_o,
  output logic [size-1:0]      b_number_o
`ifdef FP_UNPACK_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [15:0]          nan_count_o,
  output logic [15:0]          denorm_count_o
`endif
);

  localparam int unsigned FW = size_mantissa - 1;
  localparam int unsigned EW = size_exponent;
  localparam int unsigned XW = size_exception_field;

  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                 s1_sub_q, s1_sub_d, s2_sub_q, s2_sub_d;
  logic [ieee_size-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [size-1:0]      s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic                 s1_adv, s2_adv;

  function automatic logic is_nan(input logic [ieee_size-1:0] w);
    return (&w[FW +: EW]) && (|w[FW-1:0]);
  endfunction

  function automatic logic is_denorm(input logic [ieee_size-1:0] w);
    return (~|w[FW +: EW]) && (|w[FW-1:0]);
  endfunction

  // Denormals flush to signed zero; NaN keeps its payload; exponent stays biased.
  function automatic logic [size-1:0] unpack(input logic [ieee_size-1:0] w);
    logic          s;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    s = w[ieee_size-1];
    e = w[FW +: EW];
    f = w[FW-1:0];
    if (~|e)
      return {XW'(zero), s, EW'(0), FW'(0)};
    else if (&e)
      return (|f) ? {XW'(NaN), s, e, f} : {XW'(infinity), s, e, FW'(0)};
    else
      return {XW'(normal_number), s, e, f};
  endfunction

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Pipeline next-state: each stage loads only when it can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sub_d   = s1_sub_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_sub_d   = s2_sub_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sub_d = sub_i;
        s1_a_d   = a_ieee_i;
        s1_b_d   = b_ieee_i;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sub_d = s1_sub_q;
        s2_a_d   = unpack(s1_a_q);
        s2_b_d   = unpack(s1_b_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sub_q   <= s1_sub_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_sub_q   <= s2_sub_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign sub_o      = s2_sub_q;
  assign a_number_o = s2_a_q;
  assign b_number_o = s2_b_q;

`ifdef FP_UNPACK_STATS_EN
  logic [15:0] nan_cnt_q, nan_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [1:0]  nan_inc, dn_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, c} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Counters advance as a pair moves into stage 2; a clear overrides that cycle's increment.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    dn_cnt_d  = dn_cnt_q;
    nan_inc   = 2'(is_nan(s1_a_q)) + 2'(is_nan(s1_b_q));
    dn_inc    = 2'(is_denorm(s1_a_q)) + 2'(is_denorm(s1_b_q));
    if (stats_clr) begin
      nan_cnt_d = '0;
      dn_cnt_d  = '0;
    end else if (s1_valid_q && s2_adv) begin
      nan_cnt_d = sat_add(nan_cnt_q, nan_inc);
      dn_cnt_d  = sat_add(dn_cnt_q, dn_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nan_cnt_q <= '0;
      dn_cnt_q  <= '0;
    end else begin
      nan_cnt_q <= nan_cnt_d;
      dn_cnt_q  <= dn_cnt_d;
    end
  end

  assign nan_count_o    = nan_cnt_q;
  assign denorm_count_o = dn_cnt_q;
`endif

endmodule
